pixie_dp_back_end: RTL
======================

Name: pixie_dp_back_end

Overview:
Scan-out side of the Pixie display path. It reads the 1024-byte frame buffer (128 rows × 8 bytes, MSB = leftmost pixel) that the DMA front end fills. It serialises each byte into pixels and generates the raster timing (sync, blank) for the video output stage. It sits between the dual-port frame-buffer RAM read port and the video encoder/scaler.

Parameters:
PIX_REP, 4, pixel-clock ticks per source pixel; H_ACTIVE = 64*PIX_REP (localparam)
H_TOTAL, 320, ticks per line
H_SYNC_START, 272, first tick with hsync_n low
H_SYNC_END, 296, first tick after hsync_n low
V_TOTAL, 262, lines per frame
V_ACTIVE, 128, active lines; line v reads row v
V_SYNC_START, 180, first line with vsync_n low
V_SYNC_END, 184, first line after vsync_n low

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_enable  in  1  pixel tick; counters advance only when high
mem_addr  out  10  frame-buffer read address {row[6:0], byte[2:0]}
mem_rd_en  out  1  one-clk read strobe
mem_data  in  8  RAM read data, valid on the second clk edge after the mem_rd_en edge
video  out  2  luminance: 2'b11 lit, 2'b00 dark
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
hblank  out  1  high when h >= H_ACTIVE
vblank  out  1  high when v >= V_ACTIVE

Behaviour:
- Reset (async): h=0, v=0, mem_rd_en=0, mem_addr=0, shift/hold regs=0, video=0, hsync_n=1, vsync_n=1, hblank=0, vblank=0, fetch FSM=IDLE.
- h counts 0..H_TOTAL-1 on clk_enable, then wraps to 0. v increments when h wraps and itself wraps from V_TOTAL-1 to 0.
- All outputs are registered. They update on the tick edge and reflect the new (h,v). They hold between ticks.
- Byte k (0..7) of a line occupies h = 8*PIX_REP*k .. 8*PIX_REP*(k+1)-1.
- Fetch issue rules:
  - Byte k>0 is issued on the tick where h == 8*PIX_REP*k-3.
  - Byte 0 is issued on the tick where h == H_TOTAL-3 of the previous line, with row = (v+1) mod V_TOTAL.
  - Issue happens only if the target line is < V_ACTIVE.
  - On issue: mem_addr <= {row, k}, mem_rd_en <= 1 for exactly one clk.
- Fetch FSM (per clk, not per tick):
  - IDLE -> WAIT on issue.
  - WAIT -> CAPT after one clk (RAM latency).
  - CAPT: hold <= mem_data; -> IDLE.
  - Total: data is captured 2 clks after issue. This is always before the byte-start tick, because ticks are at most one per clk.
- Serialiser:
  - On the tick where h == byte start and the line is active: shift <= hold.
  - The shift register moves left every PIX_REP ticks.
  - video = shift[7] ? 2'b11 : 2'b00 while h < H_ACTIVE and v < V_ACTIVE; otherwise 2'b00.
- hsync_n = !(H_SYNC_START <= h < H_SYNC_END).
- vsync_n = !(V_SYNC_START <= v < V_SYNC_END). It changes only when h wraps.
- Boundaries:
  - Line V_ACTIVE-1 issues no byte-0 fetch for line V_ACTIVE.
  - Line V_TOTAL-1 issues row 0.
  - Gaps in clk_enable freeze all state except the fetch FSM, which completes independently.
  - A reset mid-fetch aborts the fetch and raster restarts at (0,0). Line 0 after reset displays hold=0 for byte 0, which is dark; this is accepted.

Optional Feature:
PIXIE_SCANLINE_EN:
- With it: lit pixels on odd active lines (v[0]=1) output 2'b01 (half intensity); even lines output 2'b11.
- Without it: every lit pixel is 2'b11.
- Timing and fetch are identical in both builds.

Decomposition:
- pixie_pkg holds:
  - frame-buffer geometry constants: FB_ROWS=128, FB_BYTES_PER_ROW=8, FB_ADDR_W=10;
  - the video luminance encodings (LUM_LIT, LUM_DIM, LUM_DARK);
  - the fetch-state enum (IDLE, WAIT, CAPT).
- One natural sub-module: pixie_raster_timing. It holds the h/v counters and sync/blank decode, and exports h, v and the tick-qualified fetch/load strobes. The fetch FSM and serialiser stay in the top.

Test Plan:
- Reset → all outputs at reset values. After release with clk_enable=1, hsync_n falls exactly at h=272 and rises at h=296; vsync_n is low for lines 180-183 only.
- RAM[0]=8'hA5, clk_enable=1 every clk → line 0, h=0..31 shows video 11,00,11,00,00,11,00,11 with each pixel held 4 ticks.
- Line 5 → mem_rd_en pulses with addr 40 at h=317 of line 4, then addr 41..47 at h=29,61,...,221. There are no pulses on lines 127 (for 128) through 260.
- clk_enable high every 3rd clk, RAM[8]=8'hFF → identical tick-level pattern to the full-rate case; row 1 is fully lit for h=0..31.
- Wrap: line 261, h=317 → mem_addr=0; line 0 byte 0 is correct. Assert reset during line 10 WAIT → outputs reset immediately and the next frame is correct.
- PIXIE_SCANLINE_EN defined, all RAM=8'hFF → video=2'b11 on line 0 and 2'b01 on line 1.

Source files
------------

// File: rtl/pixie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixie_pkg
// Purpose  : Shared definitions for the Pixie display back end: frame-buffer
//            geometry, video luminance encodings and the fetch-state enum.
// Revision : 1.0 - initial release
// ============================================================================
package pixie_pkg;

    // Frame buffer: 128 rows x 8 bytes, address = {row, byte}
    localparam int FB_ROWS          = 128;
    localparam int FB_BYTES_PER_ROW = 8;
    localparam int FB_ADDR_W        = 10;

    // Video luminance codes
    localparam logic [1:0] LUM_LIT  = 2'b11;
    localparam logic [1:0] LUM_DIM  = 2'b01;
    localparam logic [1:0] LUM_DARK = 2'b00;

    // Frame-buffer read sequencing: issue, RAM latency, capture
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } fetch_state_t;

endpackage : pixie_pkg
`default_nettype wire

// File: rtl/pixie_raster_timing.sv
`default_nettype none
// ============================================================================
// Module   : pixie_raster_timing
// Purpose  : Horizontal/vertical raster counters with registered sync and
//            blank decode, plus tick-qualified strobes for the fetch and
//            serialiser logic in the top level.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            clk_enable          - pixel tick
//            h, v                - raster position that takes effect at the
//                                  coming edge (equals the counters between
//                                  ticks)
//            hsync_n, vsync_n    - registered syncs, active low
//            hblank, vblank      - registered blanks
//            pixel_active        - position (h,v) lies in the active picture
//            fetch_strobe        - issue a frame-buffer read this edge
//            fetch_first         - the read is byte 0 of the next line
//            load_strobe         - load the serialiser from the hold register
//            shift_strobe        - advance the serialiser by one pixel
// Revision : 1.0 - initial release
// ============================================================================
module pixie_raster_timing #(
    parameter int PIX_REP      = 4,
    parameter int H_TOTAL      = 320,
    parameter int H_SYNC_START = 272,
    parameter int H_SYNC_END   = 296,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 128,
    parameter int V_SYNC_START = 180,
    parameter int V_SYNC_END   = 184,
    localparam int H_W         = $clog2(H_TOTAL + 4),
    localparam int V_W         = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_enable,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           hsync_n,
    output logic           vsync_n,
    output logic           hblank,
    output logic           vblank,
    output logic           pixel_active,
    output logic           fetch_strobe,
    output logic           fetch_first,
    output logic           load_strobe,
    output logic           shift_strobe
);

    localparam int H_ACTIVE  = 64 * PIX_REP;
    localparam int BYTE_SPAN = 8 * PIX_REP;

    localparam logic [H_W-1:0] c_H_LAST        = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] c_H_ACTIVE      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] c_H_SYNC_START  = H_W'(H_SYNC_START);
    localparam logic [H_W-1:0] c_H_SYNC_END    = H_W'(H_SYNC_END);
    localparam logic [H_W-1:0] c_H_BYTE0_ISSUE = H_W'(H_TOTAL - 3);
    localparam logic [H_W-1:0] c_BYTE_SPAN     = H_W'(BYTE_SPAN);
    localparam logic [H_W-1:0] c_PIX_REP       = H_W'(PIX_REP);
    localparam logic [V_W-1:0] c_V_LAST        = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_ACTIVE      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] c_V_SYNC_START  = V_W'(V_SYNC_START);
    localparam logic [V_W-1:0] c_V_SYNC_END    = V_W'(V_SYNC_END);

    logic [H_W-1:0] r_h;
    logic [V_W-1:0] r_v;
    logic [H_W-1:0] w_h_next;
    logic [V_W-1:0] w_v_next;
    logic [V_W-1:0] w_next_line;
    logic [H_W-1:0] w_h_plus3;
    logic           w_fetch_rest;

    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (clk_enable) begin
            if (r_h == c_H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v == c_V_LAST) ? '0 : r_v + V_W'(1);
            end else begin
                w_h_next = r_h + H_W'(1);
            end
        end
    end

    assign h = w_h_next;
    assign v = w_v_next;

    // Reads lead each byte start by 3 ticks so the 2-clk RAM round trip
    // lands in the hold register before the serialiser needs it.
    assign w_next_line  = (w_v_next == c_V_LAST) ? '0 : w_v_next + V_W'(1);
    assign w_h_plus3    = w_h_next + H_W'(3);
    assign fetch_first  = clk_enable && (w_h_next == c_H_BYTE0_ISSUE)
                          && (w_next_line < c_V_ACTIVE);
    assign w_fetch_rest = clk_enable && ((w_h_plus3 % c_BYTE_SPAN) == '0)
                          && (w_h_plus3 >= c_BYTE_SPAN) && (w_h_plus3 < c_H_ACTIVE)
                          && (w_v_next < c_V_ACTIVE);
    assign fetch_strobe = fetch_first || w_fetch_rest;

    assign pixel_active = (w_h_next < c_H_ACTIVE) && (w_v_next < c_V_ACTIVE);
    assign load_strobe  = clk_enable && pixel_active && ((w_h_next % c_BYTE_SPAN) == '0);
    assign shift_strobe = clk_enable && pixel_active && ((w_h_next % c_PIX_REP) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h     <= '0;
            r_v     <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            hblank  <= 1'b0;
            vblank  <= 1'b0;
        end else begin
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            hsync_n <= !((w_h_next >= c_H_SYNC_START) && (w_h_next < c_H_SYNC_END));
            vsync_n <= !((w_v_next >= c_V_SYNC_START) && (w_v_next < c_V_SYNC_END));
            hblank  <= (w_h_next >= c_H_ACTIVE);
            vblank  <= (w_v_next >= c_V_ACTIVE);
        end
    end

endmodule : pixie_raster_timing
`default_nettype wire

// File: rtl/pixie_dp_back_end.sv
`default_nettype none
// ============================================================================
// Module   : pixie_dp_back_end
// Purpose  : Scan-out side of the Pixie display path. Fetches frame-buffer
//            bytes ahead of the beam, serialises them MSB-first into pixels
//            and drives registered video, sync and blank outputs.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            clk_enable          - pixel tick
//            mem_addr, mem_rd_en - frame-buffer read port {row, byte}
//            mem_data            - read data, valid 2 clks after the strobe
//            video               - 2-bit luminance
//            hsync_n, vsync_n    - syncs, active low
//            hblank, vblank      - blanking flags
// Options  : PIXIE_SCANLINE_EN - lit pixels on odd active lines use the dim
//            luminance code; timing and fetch are unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module pixie_dp_back_end
    import pixie_pkg::*;
#(
    parameter int PIX_REP      = 4,
    parameter int H_TOTAL      = 320,
    parameter int H_SYNC_START = 272,
    parameter int H_SYNC_END   = 296,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 128,
    parameter int V_SYNC_START = 180,
    parameter int V_SYNC_END   = 184
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_enable,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic                 mem_rd_en,
    input  logic [7:0]           mem_data,
    output logic [1:0]           video,
    output logic                 hsync_n,
    output logic                 vsync_n,
    output logic                 hblank,
    output logic                 vblank
);

    localparam int H_W    = $clog2(H_TOTAL + 4);
    localparam int V_W    = $clog2(V_TOTAL);
    localparam int BYTE_W = $clog2(FB_BYTES_PER_ROW);
    localparam int ROW_W  = FB_ADDR_W - BYTE_W;

    localparam logic [H_W-1:0] c_BYTE_SPAN = H_W'(8 * PIX_REP);
    localparam logic [V_W-1:0] c_V_LAST    = V_W'(V_TOTAL - 1);

    logic [H_W-1:0]       h;
    logic [V_W-1:0]       v;
    logic                 pixel_active;
    logic                 fetch_strobe;
    logic                 fetch_first;
    logic                 load_strobe;
    logic                 shift_strobe;

    logic [H_W-1:0]       w_h_plus3;
    logic [V_W-1:0]       w_fetch_row;
    logic [BYTE_W-1:0]    w_fetch_byte;
    logic [FB_ADDR_W-1:0] w_fetch_addr;
    logic [7:0]           w_shift_next;
    logic [1:0]           w_lum_on;

    fetch_state_t         r_fetch_state;
    logic [7:0]           r_hold;
    logic [7:0]           r_shift;

    pixie_raster_timing #(
        .PIX_REP      (PIX_REP),
        .H_TOTAL      (H_TOTAL),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_END   (H_SYNC_END),
        .V_TOTAL      (V_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_END   (V_SYNC_END)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .h            (h),
        .v            (v),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .hblank       (hblank),
        .vblank       (vblank),
        .pixel_active (pixel_active),
        .fetch_strobe (fetch_strobe),
        .fetch_first  (fetch_first),
        .load_strobe  (load_strobe),
        .shift_strobe (shift_strobe)
    );

    // Byte 0 is fetched at the tail of the previous line, so it targets the
    // following row; later bytes belong to the current row.
    assign w_h_plus3    = h + H_W'(3);
    assign w_fetch_row  = fetch_first ? ((v == c_V_LAST) ? '0 : v + V_W'(1)) : v;
    assign w_fetch_byte = fetch_first ? '0 : BYTE_W'(w_h_plus3 / c_BYTE_SPAN);
    assign w_fetch_addr = {ROW_W'(w_fetch_row), w_fetch_byte};

`ifdef PIXIE_SCANLINE_EN
    assign w_lum_on = v[0] ? LUM_DIM : LUM_LIT;
`else
    assign w_lum_on = LUM_LIT;
`endif

    // Fetch sequencer runs every clk regardless of clk_enable, so a read in
    // flight always completes within two clks of its issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_state <= IDLE;
            mem_addr      <= '0;
            mem_rd_en     <= 1'b0;
            r_hold        <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            case (r_fetch_state)
                IDLE: begin
                    if (fetch_strobe) begin
                        mem_addr      <= w_fetch_addr;
                        mem_rd_en     <= 1'b1;
                        r_fetch_state <= WAIT;
                    end
                end
                WAIT: r_fetch_state <= CAPT;
                CAPT: begin
                    r_hold        <= mem_data;
                    r_fetch_state <= IDLE;
                end
                default: r_fetch_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_shift_next = r_shift;
        if (load_strobe) begin
            w_shift_next = r_hold;
        end else if (shift_strobe) begin
            w_shift_next = {r_shift[6:0], 1'b0};
        end
    end

    // Video is decoded from the next shift value so it lines up with the
    // registered sync/blank outputs of the same tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            video   <= LUM_DARK;
        end else begin
            r_shift <= w_shift_next;
            video   <= (pixel_active && w_shift_next[7]) ? w_lum_on : LUM_DARK;
        end
    end

endmodule : pixie_dp_back_end
`default_nettype wire
